// File: rtl/sevenseg_scan_decoder.sv
// Receiver for a time-multiplexed seven-segment bus: validates each digit dwell,
// decodes segment patterns back to hex and publishes complete frames with a strobe.
module sevenseg_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter int STABLE_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_valid,
  output logic                    err_seg,
  output logic                    err_an
);

  localparam int             CW      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ARM = CW'(STABLE_CYCLES - 2);

  // Returns {unrecognised, blank, value} for an active-high g..a pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat);
    logic [5:0] res;
    res = {1'b1, 1'b0, 4'h0};
    case (pat)
      7'h3F:   res = {1'b0, 1'b0, 4'h0};
      7'h06:   res = {1'b0, 1'b0, 4'h1};
      7'h5B:   res = {1'b0, 1'b0, 4'h2};
      7'h4F:   res = {1'b0, 1'b0, 4'h3};
      7'h66:   res = {1'b0, 1'b0, 4'h4};
      7'h6D:   res = {1'b0, 1'b0, 4'h5};
      7'h7D:   res = {1'b0, 1'b0, 4'h6};
      7'h07:   res = {1'b0, 1'b0, 4'h7};
      7'h7F:   res = {1'b0, 1'b0, 4'h8};
      7'h6F:   res = {1'b0, 1'b0, 4'h9};
      7'h77:   res = {1'b0, 1'b0, 4'hA};
      7'h7C:   res = {1'b0, 1'b0, 4'hB};
      7'h39:   res = {1'b0, 1'b0, 4'hC};
      7'h5E:   res = {1'b0, 1'b0, 4'hD};
      7'h79:   res = {1'b0, 1'b0, 4'hE};
      7'h71:   res = {1'b0, 1'b0, 4'hF};
      7'h00:   res = {1'b0, 1'b1, 4'h0};
      default: res = {1'b1, 1'b0, 4'h0};
    endcase
    return res;
  endfunction

  logic [6:0]              seg_norm_s;
  logic [NUM_DIGITS-1:0]   an_norm_s;
  logic [6:0]              samp_seg_r;
  logic [6:0]              prev_seg_r;
  logic [NUM_DIGITS-1:0]   samp_an_r;
  logic [NUM_DIGITS-1:0]   prev_an_r;
  logic [CW-1:0]           cnt_r;
  logic [CW-1:0]           cnt_next_s;
  logic                    same_s;
  logic                    one_an_s;
  logic                    multi_an_s;
  logic                    stable_s;
  logic                    capture_s;
  logic                    frame_done_s;
  logic [5:0]              dec_s;
  logic [NUM_DIGITS-1:0]   seen_r;
  logic [NUM_DIGITS-1:0]   seen_next_s;
  logic [4*NUM_DIGITS-1:0] shadow_val_r;
  logic [NUM_DIGITS-1:0]   shadow_blank_r;
  logic                    seg_err_new_s;
  logic                    an_err_new_s;

  // Normalise pin polarity to active-high lit / selected.
  always_comb begin
    seg_norm_s = SEG_ACTIVE_LOW ? ~seg : seg;
    an_norm_s  = AN_ACTIVE_LOW  ? ~an  : an;
  end

  // Classify the current sample against the previous one.
  always_comb begin
    same_s       = (samp_seg_r == prev_seg_r) && (samp_an_r == prev_an_r);
    one_an_s     = $onehot(samp_an_r);
    multi_an_s   = (samp_an_r != {NUM_DIGITS{1'b0}}) && !one_an_s;
    stable_s     = same_s && one_an_s;
    dec_s        = decode_seg(samp_seg_r);
    frame_done_s = &seen_r;
  end

  // Dwell counter saturates, so a held digit is captured only on the arming transition.
  always_comb begin
    cnt_next_s = {CW{1'b0}};
    capture_s  = 1'b0;
    if (stable_s) begin
      if (cnt_r == CNT_MAX) begin
        cnt_next_s = CNT_MAX;
      end else begin
        cnt_next_s = cnt_r + CW'(1'b1);
      end
      capture_s = (cnt_r == CNT_ARM);
    end else begin
      cnt_next_s = {CW{1'b0}};
      capture_s  = 1'b0;
    end
  end

  // A capture on the completion edge belongs to the following frame.
  always_comb begin
    if (frame_done_s) begin
      seen_next_s = {NUM_DIGITS{1'b0}};
    end else begin
      seen_next_s = seen_r;
    end
    if (capture_s) begin
      seen_next_s = seen_next_s | samp_an_r;
    end else begin
      seen_next_s = seen_next_s;
    end
    seg_err_new_s = capture_s && dec_s[5];
    an_err_new_s  = multi_an_s;
  end

  // Input sample pipeline, dwell counter and seen mask.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_seg_r <= 7'h00;
      prev_seg_r <= 7'h00;
      samp_an_r  <= {NUM_DIGITS{1'b0}};
      prev_an_r  <= {NUM_DIGITS{1'b0}};
      cnt_r      <= {CW{1'b0}};
      seen_r     <= {NUM_DIGITS{1'b0}};
    end else begin
      samp_seg_r <= seg_norm_s;
      prev_seg_r <= samp_seg_r;
      samp_an_r  <= an_norm_s;
      prev_an_r  <= samp_an_r;
      cnt_r      <= cnt_next_s;
      seen_r     <= seen_next_s;
    end
  end

  // Shadow frame: the latest capture of each digit wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val_r   <= {(4*NUM_DIGITS){1'b0}};
      shadow_blank_r <= {NUM_DIGITS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture_s && samp_an_r[i]) begin
          shadow_val_r[4*i +: 4] <= dec_s[3:0];
          shadow_blank_r[i]      <= dec_s[4];
        end
      end
    end
  end

  // Publish the completed frame with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_out  <= {(4*NUM_DIGITS){1'b0}};
      blank_mask  <= {NUM_DIGITS{1'b0}};
      frame_valid <= 1'b0;
    end else begin
      if (frame_done_s) begin
        digits_out <= shadow_val_r;
        blank_mask <= shadow_blank_r;
      end
      frame_valid <= frame_done_s;
    end
  end

  // Sticky error flags; a fresh error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_seg <= 1'b0;
      err_an  <= 1'b0;
    end else if (err_clr) begin
      err_seg <= seg_err_new_s;
      err_an  <= an_err_new_s;
    end else begin
      err_seg <= err_seg | seg_err_new_s;
      err_an  <= err_an | an_err_new_s;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: frame table, hand-written corner sequences and
// random scans checked every cycle against a dwell-length reference model.
module tb_sevenseg_scan_decoder;
  localparam int ND = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic        err_clr = 1'b0;
  logic [15:0] digits_out;
  logic [3:0]  blank_mask;
  logic        frame_valid;
  logic        err_seg;
  logic        err_an;

  sevenseg_scan_decoder #(
    .NUM_DIGITS(ND), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .err_clr(err_clr),
    .digits_out(digits_out), .blank_mask(blank_mask), .frame_valid(frame_valid),
    .err_seg(err_seg), .err_an(err_an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
  } samp_t;

  typedef struct packed {
    logic [27:0] pats;
    logic [15:0] dig;
    logic [3:0]  blank;
    logic        err;
  } vec_t;

  samp_t       hist[$];
  logic [6:0]  pats [16];
  vec_t        tbl [5];
  logic [15:0] m_sh_val = 16'h0;
  logic [3:0]  m_sh_blank = 4'h0;
  logic [3:0]  m_seen = 4'h0;
  logic [15:0] m_digits = 16'h0;
  logic [3:0]  m_blank = 4'h0;
  logic        m_fv = 1'b0;
  logic        m_eseg = 1'b0;
  logic        m_ean = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;
  int          fv_cnt = 0;
  logic [15:0] fv_digits = 16'h0;
  logic [3:0]  fv_blank = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (pats[k] == p) return k;
    if (p == 7'h00) return 16;
    return -1;
  endfunction

  // Reference: a digit is captured when the sample run ending one edge ago is exactly SC long.
  task automatic model_edge(input logic [6:0] p, input logic [3:0] a, input logic clr, input logic rst);
    samp_t s;
    int    run;
    int    code;
    int    idx;
    logic  cap;
    logic  new_seg;
    logic  new_an;
    s.seg = p;
    s.an  = a;
    if (rst) begin
      m_sh_val = 16'h0; m_sh_blank = 4'h0; m_seen = 4'h0;
      m_digits = 16'h0; m_blank = 4'h0; m_fv = 1'b0; m_eseg = 1'b0; m_ean = 1'b0;
      hist.delete();
      s = '0;
      hist.push_front(s);
    end else begin
      run = 0;
      if (hist.size() > 0 && $countones(hist[0].an) == 1) begin
        for (int k = 0; k < hist.size(); k++) begin
          if (hist[k] == hist[0]) run++;
          else break;
        end
      end
      cap    = (run == SC);
      new_an = (hist.size() > 0) && ($countones(hist[0].an) > 1);
      m_fv   = (m_seen == 4'hF);
      if (m_fv) begin
        m_digits = m_sh_val;
        m_blank  = m_sh_blank;
        m_seen   = 4'h0;
      end
      new_seg = 1'b0;
      if (cap) begin
        idx = 0;
        for (int k = 0; k < ND; k++) if (hist[0].an[k]) idx = k;
        code = lookup(hist[0].seg);
        m_sh_val[4*idx +: 4] = (code >= 0 && code < 16) ? code[3:0] : 4'h0;
        m_sh_blank[idx]      = (code == 16);
        new_seg              = (code < 0);
        m_seen[idx]          = 1'b1;
      end
      m_eseg = clr ? new_seg : (m_eseg | new_seg);
      m_ean  = clr ? new_an  : (m_ean | new_an);
      hist.push_front(s);
      if (hist.size() > SC + 1) void'(hist.pop_back());
    end
  endtask

  task automatic step(input logic [6:0] p, input logic [3:0] a, input logic clr, input logic rst);
    seg = ~p;
    an = ~a;
    err_clr = clr;
    rst_n = ~rst;
    @(posedge clk);
    model_edge(p, a, clr, rst);
    #1;
    chk("digits_out", {16'h0, digits_out}, {16'h0, m_digits});
    chk("blank_mask", {28'h0, blank_mask}, {28'h0, m_blank});
    chk("frame_valid", {31'h0, frame_valid}, {31'h0, m_fv});
    chk("err_seg", {31'h0, err_seg}, {31'h0, m_eseg});
    chk("err_an", {31'h0, err_an}, {31'h0, m_ean});
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      fv_digits = digits_out;
      fv_blank  = blank_mask;
    end
  endtask

  task automatic scan(input logic [27:0] ps, input int dwell);
    for (int d = 0; d < ND; d++) repeat (dwell) step(ps[7*d +: 7], 4'(1 << d), 1'b0, 1'b0);
    repeat (2) step(7'h00, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int         kind;
    int         dw;
    int         pi;
    logic [3:0] a;
    logic [6:0] p;
    pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    tbl[0] = {7'h66, 7'h4F, 7'h5B, 7'h06, 16'h4321, 4'b0000, 1'b0};
    tbl[1] = {7'h77, 7'h6F, 7'h7F, 7'h3F, 16'hA980, 4'b0000, 1'b0};
    tbl[2] = {7'h79, 7'h5E, 7'h39, 7'h7C, 16'hEDCB, 4'b0000, 1'b0};
    tbl[3] = {7'h07, 7'h7D, 7'h6D, 7'h71, 16'h765F, 4'b0000, 1'b0};
    tbl[4] = {7'h55, 7'h00, 7'h06, 7'h06, 16'h0011, 4'b0100, 1'b1};

    // Reset with random pins, then no frame while idle.
    repeat (3) step(7'($urandom), 4'($urandom), 1'b0, 1'b1);
    chk("rst_digits", {16'h0, digits_out}, 32'h0);
    chk("rst_blank", {28'h0, blank_mask}, 32'h0);
    chk("rst_errs", {30'h0, err_seg, err_an}, 32'h0);
    fv_cnt = 0;
    repeat (SC + 1) step(7'h00, 4'h0, 1'b0, 1'b0);
    chk("rst_no_frame", fv_cnt, 32'd0);

    // Frame table.
    for (int i = 0; i < 5; i++) begin
      fv_cnt = 0;
      scan(tbl[i].pats, 8);
      chk("tbl_frame_count", fv_cnt, 32'd1);
      chk("tbl_digits", {16'h0, fv_digits}, {16'h0, tbl[i].dig});
      chk("tbl_blank", {28'h0, fv_blank}, {28'h0, tbl[i].blank});
      chk("tbl_err_seg", {31'h0, err_seg}, {31'h0, tbl[i].err});
    end
    step(7'h00, 4'h0, 1'b1, 1'b0);
    chk("err_seg_cleared", {31'h0, err_seg}, 32'h0);

    // Short dwell on digit 0 is not captured.
    fv_cnt = 0;
    repeat (SC - 1) step(7'h6D, 4'b0001, 1'b0, 1'b0);
    repeat (8) step(7'h06, 4'b0010, 1'b0, 1'b0);
    repeat (8) step(7'h5B, 4'b0100, 1'b0, 1'b0);
    repeat (8) step(7'h4F, 4'b1000, 1'b0, 1'b0);
    repeat (2) step(7'h00, 4'h0, 1'b0, 1'b0);
    chk("short_no_frame", fv_cnt, 32'd0);
    repeat (8) step(7'h6F, 4'b0001, 1'b0, 1'b0);
    chk("short_frame_count", fv_cnt, 32'd1);
    chk("short_digits", {16'h0, fv_digits}, 32'h3219);

    // Ghosting mid-frame.
    fv_cnt = 0;
    repeat (8) step(7'h06, 4'b0001, 1'b0, 1'b0);
    repeat (8) step(7'h5B, 4'b0010, 1'b0, 1'b0);
    repeat (5) step(7'h4F, 4'b0011, 1'b0, 1'b0);
    repeat (8) step(7'h4F, 4'b0100, 1'b0, 1'b0);
    repeat (8) step(7'h66, 4'b1000, 1'b0, 1'b0);
    repeat (2) step(7'h00, 4'h0, 1'b0, 1'b0);
    chk("ghost_err_an", {31'h0, err_an}, 32'h1);
    chk("ghost_frame_count", fv_cnt, 32'd1);
    chk("ghost_digits", {16'h0, fv_digits}, 32'h4321);
    step(7'h00, 4'h0, 1'b1, 1'b0);
    chk("clr_err_an", {31'h0, err_an}, 32'h0);
    step(7'h06, 4'b0011, 1'b0, 1'b0);
    step(7'h06, 4'b0011, 1'b1, 1'b0);
    chk("err_wins_over_clr", {31'h0, err_an}, 32'h1);
    repeat (2) step(7'h00, 4'h0, 1'b1, 1'b0);

    // Reset discards a partial frame.
    fv_cnt = 0;
    repeat (8) step(7'h7F, 4'b0001, 1'b0, 1'b0);
    repeat (8) step(7'h6F, 4'b0010, 1'b0, 1'b0);
    repeat (2) step(7'h00, 4'h0, 1'b0, 1'b1);
    step(7'h00, 4'h0, 1'b0, 1'b0);
    chk("midrst_no_frame", fv_cnt, 32'd0);
    scan({7'h4F, 7'h5B, 7'h06, 7'h3F}, 6);
    chk("midrst_frame_count", fv_cnt, 32'd1);
    chk("midrst_digits", {16'h0, fv_digits}, 32'h3210);

    // Random scans against the model.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      dw   = $urandom_range(1, 8);
      pi   = $urandom_range(0, 17);
      if (kind == 0) a = 4'h0;
      else if (kind == 1) a = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
      else a = 4'(1 << $urandom_range(0, 3));
      if (pi < 16) p = pats[pi];
      else if (pi == 16) p = 7'h00;
      else p = 7'($urandom);
      repeat (dw) step(p, a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receiving end of the multiplexed seven-segment interface (seg/an) driven by the dice roller display path.
- Samples the time-multiplexed segment and anode lines and validates each digit's dwell.
- Decodes each segment pattern back to a 4-bit hex value and presents a complete, coherent frame of digits with a one-cycle valid strobe.
- Used for on-chip readback/self-check of the displayed roll, and as a bench-side monitor.

Parameters:
- NUM_DIGITS, 4: number of anodes/digits in one scan frame.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when seg bit is 0.
- AN_ACTIVE_LOW, 1: 1 = digit selected when its an bit is 0.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured (minimum 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active low.
- seg  input  7  segment lines, seg[0]=a … seg[6]=g.
- an  input  NUM_DIGITS  anode lines, an[i] selects digit i.
- err_clr  input  1  clears sticky error flags.
- digits_out  output  4*NUM_DIGITS  decoded frame, digit i at [4i+3:4i].
- blank_mask  output  NUM_DIGITS  bit i = 1 when digit i was all-segments-off in the frame.
- frame_valid  output  1  one-cycle pulse when digits_out/blank_mask update.
- err_seg  output  1  sticky: an unrecognised segment pattern was captured.
- err_an  output  1  sticky: more than one anode was active on a sample.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n). On rst_n=0 at a clock edge, all state and outputs clear:
  - digits_out=0, blank_mask=0, frame_valid=0, err_seg=0, err_an=0.
  - Stability counter=0, seen mask=0, shadow registers=0.
- Input stage: seg/an are registered once (sample S). Polarity is normalised per the parameters to active-high lit/selected. Metastability synchronisation is external.
- Stability tracking compares S with the previous sample:
  - Identical and exactly one anode active: counter increments, saturating at STABLE_CYCLES-1.
  - Anything else: counter resets to 0 and the capture arm re-enables.
- Capture occurs on the edge where the counter reaches STABLE_CYCLES-1, i.e. the STABLE_CYCLES-th identical sample.
  - The decoded value for digit index i is written to shadow[i] and seen[i] is set.
  - Exactly one capture per dwell. No recapture until the sample changes.
- Decode table (active-high, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 00 is blank: value 0, blank bit set.
  - Any other pattern: value 0, blank bit clear, err_seg set at capture.
- Anode errors:
  - Zero anodes active: blanking gap, counter reset, no error.
  - Two or more anodes active: counter reset, err_an set on that edge.
- Frame completion: on the edge after seen becomes all-ones:
  - digits_out and blank_mask load from shadow.
  - frame_valid=1 for exactly that cycle.
  - seen clears.
  - A capture occurring on the same edge as frame completion lands in the next frame (seen bit set after the clear).
- Recapture of an already-seen digit before frame completion overwrites shadow[i]. The latest value wins.
- err_clr clears sticky flags. If a new error occurs on the same edge as err_clr, the error wins (flag stays 1).
- Latency: pin change to capture is STABLE_CYCLES+1 cycles (input register plus dwell). Last capture to frame_valid is 1 cycle.
- rst_n low mid-frame discards the partial frame. No frame_valid is issued for it.

Test Plan:
- Reset: hold rst_n=0 with random seg/an for 3 cycles, then release -> all outputs 0, no frame_valid for ≥STABLE_CYCLES cycles.
- Nominal scan, active-low pins, dwell 8 cycles per digit showing 1,2,3,4 (seg=~06,~5B,~4F,~66; an=~0001,~0010,~0100,~1000) -> single frame_valid pulse one cycle after digit 3 capture, digits_out=16'h4321, blank_mask=0, no errors.
- Short dwell: digit 0 held only STABLE_CYCLES-1=3 identical samples -> no capture; the frame completes only after a later dwell of ≥4 samples on digit 0.
- Blank plus invalid: digit 2 seg=00, digit 3 seg=0x55 -> blank_mask=4'b0100, digit 3 value 0, err_seg=1. Pulse err_clr -> err_seg=0.
- Ghosting: an=~0011 for 5 cycles mid-frame -> err_an=1, no capture during that window, frame still completes correctly afterwards.
- Reset mid-frame: rst_n low after digits 0–1 captured -> no frame_valid. Next full scan produces a frame containing only newly captured values.
